// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit paths.
//   UART_DATA_BITS    : payload bits per frame (8N1 framing)
//   UART_CLKS_PER_BIT : default clk cycles per bit (100 MHz / 115200)
//   rx_state_e        : receive state machine encoding
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronised output (two clk cycles of latency)
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver that pushes each good byte into a standard FIFO write port.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   full      : FIFO full flag, looked at only when the stop bit is sampled
//   wr_en     : one-cycle FIFO write strobe
//   din       : FIFO write data, held between writes
//   rx_busy   : high whenever the receiver is not idle
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good byte dropped because the FIFO was full
module uart_rx_fifo_writer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      full,
  output logic                      wr_en,
  output logic [UART_DATA_BITS-1:0] din,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ZERO      = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE       = BW'(1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_e                 state_r, state_nxt_s;
  logic [CW-1:0]             cnt_r, cnt_nxt_s;
  logic [BW-1:0]             bit_r, bit_nxt_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                      done_r, done_nxt_s;
  logic                      wr_nxt_s, fe_nxt_s, ov_nxt_s;
  logic [UART_DATA_BITS-1:0] din_nxt_s;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    done_nxt_s  = 1'b0;
    wr_nxt_s    = 1'b0;
    fe_nxt_s    = 1'b0;
    ov_nxt_s    = 1'b0;
    din_nxt_s   = din;
    case (state_r)
      RX_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (!rx_s) begin
          state_nxt_s = RX_START;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        // Half a bit into the start bit: re-check it to reject glitches.
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            state_nxt_s = RX_IDLE;
          end else begin
            state_nxt_s = RX_DATA;
            bit_nxt_s   = BIT_ZERO;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {rx_s, shift_r[UART_DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
            state_nxt_s = RX_STOP;
            bit_nxt_s   = BIT_ZERO;
          end else begin
            bit_nxt_s = bit_r + BIT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        // done_r marks the pulse cycle; staying in STOP for it keeps rx_busy
        // high through the pulse and returns to IDLE right after.
        if (done_r) begin
          state_nxt_s = RX_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_BIT_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            done_nxt_s = 1'b1;
            if (full) begin
              ov_nxt_s = 1'b1;
            end else begin
              wr_nxt_s  = 1'b1;
              din_nxt_s = shift_r;
            end
          end else begin
            fe_nxt_s    = 1'b1;
            state_nxt_s = RX_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      RX_BREAK: begin
        // Hold off start detection until the line has returned high.
        cnt_nxt_s = CNT_ZERO;
        if (rx_s) begin
          state_nxt_s = RX_IDLE;
        end else begin
          state_nxt_s = RX_BREAK;
        end
      end
      default: begin
        state_nxt_s = RX_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        bit_nxt_s   = BIT_ZERO;
      end
    endcase
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= CNT_ZERO;
      bit_r     <= BIT_ZERO;
      shift_r   <= {UART_DATA_BITS{1'b0}};
      done_r    <= 1'b0;
      wr_en     <= 1'b0;
      din       <= {UART_DATA_BITS{1'b0}};
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      bit_r     <= bit_nxt_s;
      shift_r   <= shift_nxt_s;
      done_r    <= done_nxt_s;
      wr_en     <= wr_nxt_s;
      din       <= din_nxt_s;
      rx_busy   <= (state_nxt_s != RX_IDLE);
      frame_err <= fe_nxt_s;
      overrun   <= ov_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed testbench for uart_rx_fifo_writer with CLKS_PER_BIT=16 (H=8).
// A negedge monitor logs every output pulse with its cycle number; each test
// task compares the logged events against hand-computed expectations.
module tb_uart_rx_fifo_writer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       full;
  logic       wr_en;
  logic [7:0] din;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // monitor state (cumulative)
  int         wr_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int         wr_cyc [0:15];
  logic [7:0] wr_din [0:15];
  int         fe_cyc = -1, ov_cyc = -1;
  int         busy_cnt = 0, rise_cnt = 0, rise_cyc = -1;
  int         multi_cnt = 0, wr_full_cnt = 0;
  logic       prev_busy = 1'b0;

  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .full      (full),
    .wr_en     (wr_en),
    .din       (din),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/event logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 16) begin
        wr_cyc[wr_cnt] = cyc;
        wr_din[wr_cnt] = din;
      end
      wr_cnt = wr_cnt + 1;
      if (full === 1'b1) wr_full_cnt = wr_full_cnt + 1;
    end
    if (frame_err === 1'b1) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (overrun === 1'b1) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
    end
    if ((32'(wr_en === 1'b1) + 32'(frame_err === 1'b1) + 32'(overrun === 1'b1)) > 1)
      multi_cnt = multi_cnt + 1;
    if (rx_busy === 1'b1) begin
      busy_cnt = busy_cnt + 1;
      if (prev_busy !== 1'b1) begin
        rise_cnt = rise_cnt + 1;
        rise_cyc = cyc;
      end
    end
    prev_busy = rx_busy;
  end

  // Drive one frame starting at the current negedge; returns at a negedge.
  // t0 is the first cycle the DUT sees the synchronised start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, output int t0);
    t0 = cyc + 2;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; full = 1'b0;
    repeat (3) @(negedge clk);
    if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got %b exp 0", wr_en); n_fail++; end
    n_tests++;
    if (din !== 8'h00) begin $display("FAIL reset_din got %h exp 00", din); n_fail++; end
    n_tests++;
    if (rx_busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", rx_busy); n_fail++; end
    n_tests++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_fe got %b exp 0", frame_err); n_fail++; end
    n_tests++;
    if (overrun !== 1'b0) begin $display("FAIL reset_ov got %b exp 0", overrun); n_fail++; end
    n_tests++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    if (rx_busy !== 1'b0 || wr_cnt != 0) begin
      $display("FAIL idle_quiet busy %b writes %0d exp 0 0", rx_busy, wr_cnt); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_single_frame();
    int t0, wb, fb, ob, bb;
    wb = wr_cnt; fb = fe_cnt; ob = ov_cnt; bb = busy_cnt;
    send_frame(8'hA5, 1'b1, t0);
    repeat (10) @(negedge clk);
    if (wr_cnt - wb != 1) begin $display("FAIL single_wr_count got %0d exp 1", wr_cnt - wb); n_fail++; end
    n_tests++;
    if (wr_cyc[wb] != t0 + 153) begin $display("FAIL single_wr_time got %0d exp %0d", wr_cyc[wb], t0 + 153); n_fail++; end
    n_tests++;
    if (wr_din[wb] !== 8'hA5) begin $display("FAIL single_din got %h exp a5", wr_din[wb]); n_fail++; end
    n_tests++;
    if (fe_cnt != fb || ov_cnt != ob) begin $display("FAIL single_no_err fe %0d ov %0d exp 0 0", fe_cnt - fb, ov_cnt - ob); n_fail++; end
    n_tests++;
    if (rise_cyc != t0 + 1) begin $display("FAIL single_busy_rise got %0d exp %0d", rise_cyc, t0 + 1); n_fail++; end
    n_tests++;
    if (busy_cnt - bb != 153) begin $display("FAIL single_busy_len got %0d exp 153", busy_cnt - bb); n_fail++; end
    n_tests++;
    if (din !== 8'hA5 || rx_busy !== 1'b0) begin $display("FAIL single_hold din %h busy %b exp a5 0", din, rx_busy); n_fail++; end
    n_tests++;
  endtask

  task automatic test_back_to_back();
    int ta, tb, wb;
    wb = wr_cnt;
    send_frame(8'h00, 1'b1, ta);
    send_frame(8'hFF, 1'b1, tb);
    repeat (10) @(negedge clk);
    if (wr_cnt - wb != 2) begin $display("FAIL b2b_count got %0d exp 2", wr_cnt - wb); n_fail++; end
    n_tests++;
    if (wr_cyc[wb] != ta + 153 || wr_din[wb] !== 8'h00) begin
      $display("FAIL b2b_first at %0d din %h exp %0d 00", wr_cyc[wb], wr_din[wb], ta + 153); n_fail++;
    end
    n_tests++;
    if (wr_cyc[wb+1] - wr_cyc[wb] != 160 || wr_din[wb+1] !== 8'hFF) begin
      $display("FAIL b2b_second gap %0d din %h exp 160 ff", wr_cyc[wb+1] - wr_cyc[wb], wr_din[wb+1]); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_overrun();
    int t0, wb, ob, fb;
    wb = wr_cnt; ob = ov_cnt; fb = fe_cnt;
    full = 1'b1;
    send_frame(8'h3C, 1'b1, t0);
    repeat (10) @(negedge clk);
    full = 1'b0;
    if (ov_cnt - ob != 1 || ov_cyc != t0 + 153) begin
      $display("FAIL ovr_pulse count %0d at %0d exp 1 %0d", ov_cnt - ob, ov_cyc, t0 + 153); n_fail++;
    end
    n_tests++;
    if (wr_cnt != wb || fe_cnt != fb) begin $display("FAIL ovr_no_write wr %0d fe %0d exp 0 0", wr_cnt - wb, fe_cnt - fb); n_fail++; end
    n_tests++;
    if (din !== 8'hFF) begin $display("FAIL ovr_din_held got %h exp ff", din); n_fail++; end
    n_tests++;
  endtask

  task automatic test_frame_err();
    int t0, t1, wb, fb, rb;
    wb = wr_cnt; fb = fe_cnt; rb = rise_cnt;
    send_frame(8'h5A, 1'b0, t0);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    if (fe_cnt - fb != 1 || fe_cyc != t0 + 153) begin
      $display("FAIL ferr_pulse count %0d at %0d exp 1 %0d", fe_cnt - fb, fe_cyc, t0 + 153); n_fail++;
    end
    n_tests++;
    if (wr_cnt != wb) begin $display("FAIL ferr_no_write got %0d exp 0", wr_cnt - wb); n_fail++; end
    n_tests++;
    if (rx_busy !== 1'b1 || rise_cnt - rb != 1) begin
      $display("FAIL ferr_break busy %b rises %0d exp 1 1", rx_busy, rise_cnt - rb); n_fail++;
    end
    n_tests++;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    if (rx_busy !== 1'b0) begin $display("FAIL ferr_release busy got %b exp 0", rx_busy); n_fail++; end
    n_tests++;
    send_frame(8'h55, 1'b1, t1);
    repeat (10) @(negedge clk);
    if (wr_cnt - wb != 1 || wr_din[wb] !== 8'h55 || wr_cyc[wb] != t1 + 153) begin
      $display("FAIL ferr_next_frame count %0d din %h at %0d exp 1 55 %0d", wr_cnt - wb, wr_din[wb], wr_cyc[wb], t1 + 153); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_glitch();
    int t0, bb, wb, fb, ob;
    bb = busy_cnt; wb = wr_cnt; fb = fe_cnt; ob = ov_cnt;
    t0 = cyc + 2;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    if (busy_cnt - bb != 8) begin $display("FAIL glitch_busy_len got %0d exp 8", busy_cnt - bb); n_fail++; end
    n_tests++;
    if (rise_cyc != t0 + 1) begin $display("FAIL glitch_busy_rise got %0d exp %0d", rise_cyc, t0 + 1); n_fail++; end
    n_tests++;
    if (wr_cnt != wb || fe_cnt != fb || ov_cnt != ob) begin
      $display("FAIL glitch_no_pulse wr %0d fe %0d ov %0d exp 0 0 0", wr_cnt - wb, fe_cnt - fb, ov_cnt - ob); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_frame();
    int t1, wb, fb, ob;
    logic [7:0] partial;
    partial = 8'h96;
    wb = wr_cnt; fb = fe_cnt; ob = ov_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    rx = partial[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    if (wr_en !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || rx_busy !== 1'b0 || din !== 8'h00) begin
      $display("FAIL midrst_outputs wr %b fe %b ov %b busy %b din %h exp 0 0 0 0 00",
               wr_en, frame_err, overrun, rx_busy, din); n_fail++;
    end
    n_tests++;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    if (wr_cnt != wb || fe_cnt != fb || ov_cnt != ob || rx_busy !== 1'b0) begin
      $display("FAIL midrst_quiet wr %0d fe %0d ov %0d busy %b exp 0 0 0 0", wr_cnt - wb, fe_cnt - fb, ov_cnt - ob, rx_busy); n_fail++;
    end
    n_tests++;
    send_frame(8'h81, 1'b1, t1);
    repeat (10) @(negedge clk);
    if (wr_cnt - wb != 1 || wr_din[wb] !== 8'h81 || wr_cyc[wb] != t1 + 153) begin
      $display("FAIL midrst_next_frame count %0d din %h at %0d exp 1 81 %0d", wr_cnt - wb, wr_din[wb], wr_cyc[wb], t1 + 153); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_exclusive();
    if (multi_cnt != 0) begin $display("FAIL pulse_exclusive got %0d exp 0", multi_cnt); n_fail++; end
    n_tests++;
    if (wr_full_cnt != 0) begin $display("FAIL write_while_full got %0d exp 0", wr_full_cnt); n_fail++; end
    n_tests++;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
